l4_parser: RTL and testbench

//  Stage downstream of the IPv4 parser. Consumes its registered pass-through beat stream plus protocol/header-length results.

---
 rtl/l4_parser_pkg.sv | 38 +++
 rtl/l4_parser_if.sv | 15 +
 rtl/l4_hdr_capture.sv | 34 +++
 rtl/l4_parser.sv | 176 +++++++++++++++++
 tb/tb_l4_parser.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l4_parser_pkg.sv
// Purpose: shared constants, FSM state type and per-lane write-enable payload
//          for the L4 header parser.
package l4_parser_pkg;

    localparam logic [7:0]  IPPROTO_TCP   = 8'd6;
    localparam logic [7:0]  IPPROTO_UDP   = 8'd17;
    localparam int unsigned IPV4_MIN_HDR  = 20;
    localparam int unsigned UDP_HDR_LEN   = 8;
    localparam int unsigned TCP_MIN_HDR   = 20;
    localparam int unsigned UDP_LAST_BYTE = UDP_HDR_LEN - 1;
    localparam int unsigned TCP_LAST_BYTE = TCP_MIN_HDR - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IP_HDR,
        ST_L4_HDR,
        ST_PAYLOAD
    } l4_state_t;

    // Which result field a given L4 header byte feeds, plus end-of-header marker
    typedef struct packed {
        logic src_hi;
        logic src_lo;
        logic dst_hi;
        logic dst_lo;
        logic len_hi;
        logic len_lo;
        logic doff;
        logic flags;
        logic last;
    } l4_lane_we_t;

    // TCP header length in bytes; data offsets below 5 are treated as 5
    function automatic logic [5:0] tcp_hdr_len(input logic [3:0] doff);
        return (doff < 4'd5) ? 6'(TCP_MIN_HDR) : {doff, 2'b00};
    endfunction

endpackage

// File: rtl/l4_parser_if.sv
// Purpose: beat stream bundle (data, valid byte count, valid, last).
// Ports  : master drives the stream, slave consumes it.
interface l4_parser_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned IDX_WIDTH = $clog2(DATA_WIDTH / 8 + 1);

    logic [DATA_WIDTH-1:0] tdata;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  data_valid;
    logic                  last_flag;

    modport master (output tdata, idx, data_valid, last_flag);
    modport slave  (input  tdata, idx, data_valid, last_flag);
endinterface

// File: rtl/l4_hdr_capture.sv
// Purpose: decode one byte lane's L4 header offset into field write enables.
// Ports  : l4o_i      - byte offset relative to the L4 header start
//          protocol_i - IPv4 protocol field
//          we_c       - combinational write enables for this lane
module l4_hdr_capture
    import l4_parser_pkg::*;
#(
    parameter int unsigned OFF_WIDTH = 17
) (
    input  logic [OFF_WIDTH-1:0] l4o_i,
    input  logic [7:0]           protocol_i,
    output l4_lane_we_t          we_c
);
    logic is_tcp;

    assign is_tcp = (protocol_i == IPPROTO_TCP);

    always_comb begin
        we_c = '0;
        case (l4o_i)
            OFF_WIDTH'(0):  we_c.src_hi = 1'b1;
            OFF_WIDTH'(1):  we_c.src_lo = 1'b1;
            OFF_WIDTH'(2):  we_c.dst_hi = 1'b1;
            OFF_WIDTH'(3):  we_c.dst_lo = 1'b1;
            OFF_WIDTH'(4):  we_c.len_hi = !is_tcp;
            OFF_WIDTH'(5):  we_c.len_lo = !is_tcp;
            OFF_WIDTH'(12): we_c.doff   = is_tcp;
            OFF_WIDTH'(13): we_c.flags  = is_tcp;
            default: ;
        endcase
        we_c.last = is_tcp ? (l4o_i == OFF_WIDTH'(TCP_LAST_BYTE))
                           : (l4o_i == OFF_WIDTH'(UDP_LAST_BYTE));
    end
endmodule

// File: rtl/l4_parser.sv
// Purpose: skip the IPv4 header, extract UDP/TCP header fields, forward the
//          beat stream one cycle later.
// Ports  : clk, rst_n           - clock, async active-low reset
//          s_in / m_out         - input stream / registered pass-through stream
//          ipv4_parser_ready, protocol, ip_hdr_len - upstream IPv4 results
//          src_port, dst_port, udp_len, tcp_flags, l4_hdr_len - L4 fields
//          l4_parser_ready, l4_unsupported - held until next packet
//          l4_err               - one-cycle pulse on truncated L4 header
module l4_parser
    import l4_parser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    l4_parser_if.slave        s_in,
    l4_parser_if.master       m_out,
    input  logic              ipv4_parser_ready,
    input  logic [7:0]        protocol,
    input  logic [5:0]        ip_hdr_len,
    output logic [15:0]       src_port,
    output logic [15:0]       dst_port,
    output logic [15:0]       udp_len,
    output logic [7:0]        tcp_flags,
    output logic [5:0]        l4_hdr_len,
    output logic              l4_parser_ready,
    output logic              l4_unsupported,
    output logic              l4_err
);
    localparam int unsigned LANES     = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = $clog2(LANES + 1);
    localparam int unsigned OFF_WIDTH = CNT_WIDTH + 1;

    l4_state_t            state_q, state_d, st;
    logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [OFF_WIDTH-1:0] cnt_sum;
    logic [15:0]          src_q, src_d, dst_q, dst_d, udp_q, udp_d;
    logic [7:0]           flags_q, flags_d, lane_byte;
    logic [5:0]           hlen_q, hlen_d;
    logic                 rdy_q, rdy_d, uns_q, uns_d, err_q, err_d;

    logic [OFF_WIDTH-1:0] off [LANES];
    logic [OFF_WIDTH-1:0] l4o [LANES];
    l4_lane_we_t          lane_we_c [LANES];

    // Per-lane packet offset and L4-relative field decode
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign off[g] = OFF_WIDTH'(byte_cnt_q) + OFF_WIDTH'(g);
        assign l4o[g] = off[g] - OFF_WIDTH'(ip_hdr_len);
        l4_hdr_capture #(.OFF_WIDTH(OFF_WIDTH)) u_cap (
            .l4o_i      (l4o[g]),
            .protocol_i (protocol),
            .we_c       (lane_we_c[g])
        );
    end

    assign cnt_sum = OFF_WIDTH'(byte_cnt_q) + OFF_WIDTH'(s_in.idx);

    // Next state: lanes walked in wire order so several transitions fit in one beat
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        src_d      = src_q;
        dst_d      = dst_q;
        udp_d      = udp_q;
        flags_d    = flags_q;
        hlen_d     = hlen_q;
        rdy_d      = rdy_q;
        uns_d      = uns_q;
        err_d      = 1'b0;
        st         = state_q;
        lane_byte  = '0;

        if (s_in.data_valid) begin
            if (state_q == ST_IDLE) begin
                src_d   = '0;
                dst_d   = '0;
                udp_d   = '0;
                flags_d = '0;
                hlen_d  = '0;
                rdy_d   = 1'b0;
                uns_d   = 1'b0;
                st      = ST_IP_HDR;
            end

            for (int i = 0; i < int'(LANES); i++) begin
                lane_byte = s_in.tdata[i*8 +: 8];
                if (IDX_WIDTH'(i) < s_in.idx) begin
                    // First L4 byte reached: protocol picks header parse or bypass
                    if (st == ST_IP_HDR && ipv4_parser_ready &&
                        off[i] >= OFF_WIDTH'(IPV4_MIN_HDR) &&
                        off[i] >= OFF_WIDTH'(ip_hdr_len)) begin
                        if (protocol == IPPROTO_TCP || protocol == IPPROTO_UDP) begin
                            st     = ST_L4_HDR;
                            hlen_d = (protocol == IPPROTO_UDP) ? 6'(UDP_HDR_LEN)
                                                               : 6'(TCP_MIN_HDR);
                        end else begin
                            uns_d = 1'b1;
                            rdy_d = 1'b1;
                            st    = ST_PAYLOAD;
                        end
                    end
                    if (st == ST_L4_HDR) begin
                        if (lane_we_c[i].src_hi) src_d[15:8] = lane_byte;
                        if (lane_we_c[i].src_lo) src_d[7:0]  = lane_byte;
                        if (lane_we_c[i].dst_hi) dst_d[15:8] = lane_byte;
                        if (lane_we_c[i].dst_lo) dst_d[7:0]  = lane_byte;
                        if (lane_we_c[i].len_hi) udp_d[15:8] = lane_byte;
                        if (lane_we_c[i].len_lo) udp_d[7:0]  = lane_byte;
                        if (lane_we_c[i].doff)   hlen_d      = tcp_hdr_len(lane_byte[7:4]);
                        if (lane_we_c[i].flags)  flags_d     = lane_byte;
                        if (lane_we_c[i].last) begin
                            rdy_d = 1'b1;
                            st    = ST_PAYLOAD;
                        end
                    end
                end
            end

            byte_cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];

            // Packet end: anything short of PAYLOAD means the L4 header was cut off
            if (s_in.last_flag) begin
                if (st != ST_PAYLOAD) err_d = 1'b1;
                st         = ST_IDLE;
                byte_cnt_d = '0;
            end
            state_d = st;
        end
    end

    // State, result and pass-through registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            byte_cnt_q       <= '0;
            src_q            <= '0;
            dst_q            <= '0;
            udp_q            <= '0;
            flags_q          <= '0;
            hlen_q           <= '0;
            rdy_q            <= 1'b0;
            uns_q            <= 1'b0;
            err_q            <= 1'b0;
            m_out.tdata      <= '0;
            m_out.idx        <= '0;
            m_out.data_valid <= 1'b0;
            m_out.last_flag  <= 1'b0;
        end else begin
            state_q          <= state_d;
            byte_cnt_q       <= byte_cnt_d;
            src_q            <= src_d;
            dst_q            <= dst_d;
            udp_q            <= udp_d;
            flags_q          <= flags_d;
            hlen_q           <= hlen_d;
            rdy_q            <= rdy_d;
            uns_q            <= uns_d;
            err_q            <= err_d;
            m_out.tdata      <= s_in.tdata;
            m_out.idx        <= s_in.idx;
            m_out.data_valid <= s_in.data_valid;
            m_out.last_flag  <= s_in.last_flag;
        end
    end

    assign src_port        = src_q;
    assign dst_port        = dst_q;
    assign udp_len         = udp_q;
    assign tcp_flags       = flags_q;
    assign l4_hdr_len      = hlen_q;
    assign l4_parser_ready = rdy_q;
    assign l4_unsupported  = uns_q;
    assign l4_err          = err_q;
endmodule

// File: tb/tb_l4_parser.sv
// Purpose: self-checking bench for l4_parser; packets are byte arrays and the
//          expected results are read straight off the header byte positions.
module tb_l4_parser;
    localparam int unsigned DW = 64;
    localparam int unsigned NB = DW / 8;
    localparam int unsigned IW = $clog2(NB + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l4_parser_if #(.DATA_WIDTH(DW)) s_if ();
    l4_parser_if #(.DATA_WIDTH(DW)) m_if ();

    logic        ipv4_rdy;
    logic [7:0]  proto;
    logic [5:0]  hlen;
    logic [15:0] src_port, dst_port, udp_len;
    logic [7:0]  tcp_flags;
    logic [5:0]  l4_hdr_len;
    logic        l4_parser_ready, l4_unsupported, l4_err;

    l4_parser #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_in              (s_if),
        .m_out             (m_if),
        .ipv4_parser_ready (ipv4_rdy),
        .protocol          (proto),
        .ip_hdr_len        (hlen),
        .src_port          (src_port),
        .dst_port          (dst_port),
        .udp_len           (udp_len),
        .tcp_flags         (tcp_flags),
        .l4_hdr_len        (l4_hdr_len),
        .l4_parser_ready   (l4_parser_ready),
        .l4_unsupported    (l4_unsupported),
        .l4_err            (l4_err)
    );

    logic [7:0] pkt_b [0:255];
    int total = 0;
    int bad   = 0;

    task automatic fill_pkt();
        for (int i = 0; i < 256; i++) pkt_b[i] = 8'($urandom);
    endtask

    task automatic idle(input int n);
        s_if.data_valid = 1'b0;
        s_if.last_flag  = 1'b0;
        s_if.idx        = '0;
        ipv4_rdy        = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one packet (mode 0: full beats, 1: random sizes with gaps,
    // 2: fixed partial-beat pattern) and checks every cycle against the byte model.
    task automatic run_packet(input logic [7:0] p, input int h, input int plen, input int mode);
        int cnt, c, beats, pat_i, need;
        bit sup, done, last, e_uns;
        logic [DW-1:0] td;
        logic [15:0] e_src, e_dst, e_udp;
        logic [7:0]  e_fl, b12;
        logic [5:0]  e_hl;
        int pat [8];
        pat = '{3, 0, 5, 7, 2, 8, 1, 4};
        sup   = (p == 8'd6) || (p == 8'd17);
        need  = (p == 8'd17) ? 8 : 20;
        e_src = sup ? {pkt_b[h], pkt_b[h+1]} : 16'h0;
        e_dst = sup ? {pkt_b[h+2], pkt_b[h+3]} : 16'h0;
        e_udp = (p == 8'd17) ? {pkt_b[h+4], pkt_b[h+5]} : 16'h0;
        e_fl  = (p == 8'd6) ? pkt_b[h+13] : 8'h0;
        b12   = pkt_b[h+12];
        if (p == 8'd17)     e_hl = 6'd8;
        else if (p == 8'd6) e_hl = (int'(b12[7:4]) < 5) ? 6'd20 : 6'(int'(b12[7:4]) * 4);
        else                e_hl = 6'd0;
        cnt = 0; beats = 0; pat_i = 0;
        while (cnt < plen) begin
            if (beats > 400) begin
                total++; bad++;
                $display("FAIL beat_budget: cnt=%0d plen=%0d", cnt, plen);
                break;
            end
            beats++;
            case (mode)
                0:       c = NB;
                1:       c = int'($urandom_range(0, NB));
                default: begin c = pat[pat_i % 8]; pat_i++; end
            endcase
            if (c > plen - cnt) c = plen - cnt;
            last = (cnt + c == plen);
            td = {32'($urandom), 32'($urandom)};
            for (int i = 0; i < c; i++) td[i*8 +: 8] = pkt_b[cnt+i];
            s_if.tdata = td; s_if.idx = IW'(c);
            s_if.data_valid = 1'b1; s_if.last_flag = last;
            ipv4_rdy = (cnt + c > 20);
            if (ipv4_rdy) begin proto = p; hlen = 6'(h); end
            else begin proto = 8'($urandom); hlen = 6'($urandom); end
            @(posedge clk); #1;
            cnt += c;
            done  = sup ? (cnt >= h + need) : (cnt > h);
            e_uns = !sup && (cnt > h);
            total++;
            if (m_if.tdata !== td || m_if.idx !== IW'(c) || m_if.data_valid !== 1'b1 || m_if.last_flag !== last) begin
                bad++;
                $display("FAIL passthru: got %h/%0d/%b/%b want %h/%0d/1/%b",
                         m_if.tdata, m_if.idx, m_if.data_valid, m_if.last_flag, td, c, last);
            end
            total++;
            if (l4_parser_ready !== done) begin
                bad++; $display("FAIL ready: cnt=%0d got %b want %b", cnt, l4_parser_ready, done);
            end
            total++;
            if (l4_unsupported !== e_uns) begin
                bad++; $display("FAIL unsupported: cnt=%0d got %b want %b", cnt, l4_unsupported, e_uns);
            end
            total++;
            if (l4_err !== (last && !done)) begin
                bad++; $display("FAIL err: cnt=%0d got %b want %b", cnt, l4_err, last && !done);
            end
            if (done) begin
                total++;
                if ({src_port, dst_port, udp_len, tcp_flags, l4_hdr_len} !== {e_src, e_dst, e_udp, e_fl, e_hl}) begin
                    bad++;
                    $display("FAIL fields: got %h %h %h %h %0d want %h %h %h %h %0d",
                             src_port, dst_port, udp_len, tcp_flags, l4_hdr_len, e_src, e_dst, e_udp, e_fl, e_hl);
                end
            end
            // Invalid cycle mid-packet: nothing may move, garbage must still pass through
            if (mode == 1 && !last && $urandom_range(0, 3) == 0) begin
                td = {32'($urandom), 32'($urandom)};
                s_if.tdata = td; s_if.idx = IW'($urandom_range(0, NB));
                s_if.data_valid = 1'b0; s_if.last_flag = 1'($urandom);
                @(posedge clk); #1;
                total++;
                if (m_if.tdata !== td || m_if.data_valid !== 1'b0 || l4_parser_ready !== done || l4_err !== 1'b0) begin
                    bad++;
                    $display("FAIL gap: tdata %h want %h v=%b rdy=%b want %b err=%b",
                             m_if.tdata, td, m_if.data_valid, l4_parser_ready, done, l4_err);
                end
            end
        end
    endtask

    task automatic test_reset();
        s_if.tdata = '0; s_if.idx = '0; s_if.data_valid = 1'b0; s_if.last_flag = 1'b0;
        ipv4_rdy = 1'b0; proto = '0; hlen = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({src_port, dst_port, udp_len, tcp_flags, l4_hdr_len, l4_parser_ready, l4_unsupported, l4_err} !== '0) begin
            bad++; $display("FAIL reset_results: got %h %h %h %h %0d %b %b %b", src_port, dst_port,
                            udp_len, tcp_flags, l4_hdr_len, l4_parser_ready, l4_unsupported, l4_err);
        end
        total++;
        if (m_if.tdata !== '0 || m_if.idx !== '0 || m_if.data_valid !== 1'b0 || m_if.last_flag !== 1'b0) begin
            bad++; $display("FAIL reset_passthru: got %h %0d %b %b", m_if.tdata, m_if.idx, m_if.data_valid, m_if.last_flag);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_udp();
        fill_pkt();
        pkt_b[20] = 8'h30; pkt_b[21] = 8'h39; pkt_b[22] = 8'h00; pkt_b[23] = 8'h35;
        pkt_b[24] = 8'h00; pkt_b[25] = 8'h1C;
        run_packet(8'd17, 20, 40, 0);
        total++;
        if (src_port !== 16'h3039 || dst_port !== 16'h0035 || udp_len !== 16'h001C || l4_hdr_len !== 6'd8 || tcp_flags !== 8'h00) begin
            bad++; $display("FAIL udp_fixed: got %h %h %h %0d %h", src_port, dst_port, udp_len, l4_hdr_len, tcp_flags);
        end
        idle(2);
    endtask

    task automatic test_tcp();
        fill_pkt();
        pkt_b[24] = 8'h00; pkt_b[25] = 8'h50; pkt_b[26] = 8'hC3; pkt_b[27] = 8'h50;
        pkt_b[36] = 8'h80; pkt_b[37] = 8'h12;
        run_packet(8'd6, 24, 24 + 32 + 10, 0);
        total++;
        if (src_port !== 16'h0050 || dst_port !== 16'hC350 || l4_hdr_len !== 6'd32 || tcp_flags !== 8'h12 ||
            udp_len !== 16'h0 || l4_parser_ready !== 1'b1) begin
            bad++; $display("FAIL tcp_fixed: got %h %h %0d %h %h %b", src_port, dst_port, l4_hdr_len,
                            tcp_flags, udp_len, l4_parser_ready);
        end
        idle(1);
        total++;
        if (l4_err !== 1'b0 || l4_parser_ready !== 1'b1) begin
            bad++; $display("FAIL tcp_hold: err=%b rdy=%b want 0 1", l4_err, l4_parser_ready);
        end
    endtask

    task automatic test_icmp();
        fill_pkt();
        run_packet(8'd1, 20, 50, 0);
        total++;
        if (l4_unsupported !== 1'b1 || l4_parser_ready !== 1'b1 || src_port !== 16'h0 || dst_port !== 16'h0) begin
            bad++; $display("FAIL icmp: got uns=%b rdy=%b src=%h dst=%h", l4_unsupported, l4_parser_ready, src_port, dst_port);
        end
        idle(2);
    endtask

    task automatic test_short();
        fill_pkt();
        run_packet(8'd17, 20, 26, 0);
        idle(1);
        total++;
        if (l4_err !== 1'b0 || l4_parser_ready !== 1'b0) begin
            bad++; $display("FAIL short_after: err=%b rdy=%b want 0 0", l4_err, l4_parser_ready);
        end
        fill_pkt();
        run_packet(8'd17, 20, 36, 0);
        idle(1);
    endtask

    task automatic test_partial();
        fill_pkt();
        run_packet(8'd17, 23, 60, 2);
        fill_pkt();
        run_packet(8'd6, 20, 64, 2);
        fill_pkt();
        run_packet(8'd6, 44, 90, 2);
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        int h, plen, need, sel;
        for (int k = 0; k < 30; k++) begin
            fill_pkt();
            sel = int'($urandom_range(0, 4));
            p = (sel < 2) ? 8'd6 : (sel < 4) ? 8'd17 : 8'($urandom_range(18, 255));
            h = int'($urandom_range(20, 60));
            need = (p == 8'd17) ? 8 : 20;
            if ($urandom_range(0, 4) == 0) plen = h + int'($urandom_range(0, need - 1));
            else                           plen = h + need + int'($urandom_range(0, 40));
            run_packet(p, h, plen, 1 + int'($urandom_range(0, 1)));
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] td;
        fill_pkt();
        pkt_b[20] = 8'hAB;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < int'(NB); i++) td[i*8 +: 8] = pkt_b[b*NB + i];
            s_if.tdata = td; s_if.idx = IW'(NB); s_if.data_valid = 1'b1; s_if.last_flag = 1'b0;
            ipv4_rdy = (b == 2); proto = 8'd6; hlen = 6'd20;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        total++;
        if ({src_port, dst_port, udp_len, tcp_flags, l4_hdr_len, l4_parser_ready, l4_unsupported, l4_err} !== '0 ||
            m_if.tdata !== '0 || m_if.data_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid: src=%h dst=%h rdy=%b out=%h v=%b", src_port, dst_port,
                            l4_parser_ready, m_if.tdata, m_if.data_valid);
        end
        s_if.data_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_pkt();
        run_packet(8'd17, 20, 45, 1);
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_udp();
        test_tcp();
        test_icmp();
        test_short();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
